fifo_ast_source: RTL and testbench
==================================

// Module: fifo_ast_source
// PURPOSE
//  Read-side drain engine for the FIFO. Pops words through the FIFO's
//  non_empty/rd port and emits them as an Avalon-ST source stream that honours
//  READY_LATENCY. It also frames the stream into fixed-length packets (sop/eop/empty).
//  Sits between the FIFO read port and a downstream Avalon-ST sink.
// PARAMETERS
//  DATABITS_PER_SYMBOL  8                                bits per symbol
//  SYMBOLS_PER_BEAT     4                                symbols per beat
//  WIDTH                DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT  data width
//  EMPTY_W              max(1,$clog2(SYMBOLS_PER_BEAT))  width of empty_o
//  READY_LATENCY        2                                Avalon-ST ready latency, 0..4
//  PKT_LEN              4                                beats per packet, >=1
//  LAST_EMPTY           0                                empty_o value on eop beat, <SYMBOLS_PER_BEAT
// PORTS
//  clk_i          in   1        clock, all logic on rising edge
//  rst_i          in   1        asynchronous, active-low reset
//  fifo_data_i    in   WIDTH    FIFO read data, valid 1 cycle after a rd_o pulse
//  fifo_nempty_i  in   1        FIFO holds >=1 word
//  fifo_rd_o      out  1        FIFO pop strobe
//  ready_i        in   1        sink ready
//  valid_o        out  1        beat valid
//  data_o         out  WIDTH    beat data
//  sop_o          out  1        first beat of packet
//  eop_o          out  1        last beat of packet
//  empty_o        out  EMPTY_W  empty symbols, only meaningful when eop_o=1
// BEHAVIOUR
//  Reset (rst_i=0, async): fifo_rd_o, valid_o, sop_o, eop_o = 0; data_o, empty_o = 0.
//   Beat counter = 0, pipelines cleared. A word popped but not yet emitted is dropped.
//   The FIFO is not reset by this block.
//  READY_LATENCY>=1:
//   - fifo_rd_o = ready_i & fifo_nempty_i, combinational; it is 0 while in reset.
//   - A pop in cycle t returns data at t+1. That data passes through a
//     READY_LATENCY-1 stage register pipeline (valid+data), so valid_o rises in cycle t+RL.
//   - valid_o=1 in cycle t+RL is legal only because ready_i was 1 at t.
//     valid_o=1 always means the beat transfers; it is never held.
//   - Throughput is 1 beat/clk while ready_i and fifo_nempty_i stay high.
//  READY_LATENCY=0:
//   - The output uses a 2-entry skid buffer. A beat transfers when valid_o & ready_i.
//   - valid_o, data_o, sop_o, eop_o and empty_o stay stable until the beat transfers.
//   - fifo_rd_o=1 only when the skid buffer can still accept the in-flight word
//     plus the new one (occupancy+inflight<2) and fifo_nempty_i=1.
//     Full throughput when ready_i is held high.
//  Framing:
//   - beat_cnt (0..PKT_LEN-1) increments on every transferred beat and wraps to 0 after PKT_LEN-1.
//   - sop_o = (beat_cnt==0); eop_o = (beat_cnt==PKT_LEN-1).
//   - PKT_LEN=1: sop_o and eop_o are both 1 on every beat.
//   - empty_o = eop_o ? LAST_EMPTY : 0. sop/eop/empty are qualified by valid_o.
//  Boundaries:
//   - FIFO goes empty mid-packet: valid_o gaps; beat_cnt holds.
//   - ready_i drops: pops stop immediately. Already-popped words still emerge
//     (RL>=1) or are held in the skid buffer (RL=0).
//   - Reset asserted mid-packet: the next packet after release starts with sop_o=1.
// STRUCTURE
//  Package fifo_ast_pkg:
//   - typedef struct packed {logic [WIDTH-1:0] data; logic sop, eop; logic [EMPTY_W-1:0] empty;} ast_beat_t
//   - localparam-based width helper; legal READY_LATENCY range constant.
//  Sub-module ast_skid_buffer (2-entry, valid/ready, async active-low reset).
//   It is instantiated only under a generate branch for READY_LATENCY==0.
//  The RL>=1 delay pipeline and framing counter live in this module.
// TESTING
//  1 RL=2, PKT_LEN=4, FIFO preloaded 0xA0..0xA7, ready_i=1 constant
//    -> 8 consecutive valid beats, first at rd+2; sop on A0,A4; eop on A3,A7.
//  2 RL=2, ready_i toggles 1,0,1,0 -> valid_o pattern equals ready_i delayed 2 clks;
//    no beat without prior ready; data order preserved.
//  3 RL=0, ready_i low 5 clks with FIFO non-empty -> valid_o=1, data_o stable,
//    pops stop at 2 buffered words; FIFO keeps the remainder.
//  4 PKT_LEN=3, LAST_EMPTY=2, 6 words -> empty_o=2 only on beats 3 and 6; 0 elsewhere.
//  5 FIFO empties after 2 beats of a packet, refilled 4 clks later
//    -> next beat has sop_o=0, beat_cnt continues at 2.
//  6 rst_i pulsed low mid-packet (after beat 2) -> outputs 0 immediately;
//    after release the first beat has sop_o=1.

Source files
------------

// File: rtl/fifo_ast_pkg.sv
// Shared types and constants for the FIFO-to-Avalon-ST drain engine.
// The beat record describes one output beat at the default bus geometry.
package fifo_ast_pkg;

    localparam int DEF_DATABITS = 8;
    localparam int DEF_SYMBOLS  = 4;
    localparam int DEF_WIDTH    = DEF_DATABITS * DEF_SYMBOLS;
    localparam int RL_MIN       = 0;
    localparam int RL_MAX       = 4;

    // Counter/field width that never collapses to zero bits.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_EMPTY_W = width_min1(DEF_SYMBOLS);

    typedef struct packed {
        logic [DEF_WIDTH-1:0]   data;
        logic                   sop;
        logic                   eop;
        logic [DEF_EMPTY_W-1:0] empty;
    } ast_beat_t;

endpackage

// File: rtl/fifo_ast_source_skid.sv
// Two-entry valid/ready skid buffer used when the sink has zero ready latency.
// Outputs come straight from registers; occupancy lets the producer throttle.
module ast_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [1:0]   cnt_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         push_s;
    logic         pop_s;

    assign pop_s  = (cnt_r != 2'd0) & out_ready;
    assign push_s = in_valid & ((cnt_r != 2'd2) | pop_s);

    // Head always holds the oldest word; tail is only used when both are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 2'd0;
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= in_data;
                    end else begin
                        tail_r <= in_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    head_r <= tail_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        head_r <= in_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_data;
                    end
                end
                default: begin
                    cnt_r  <= cnt_r;
                    head_r <= head_r;
                    tail_r <= tail_r;
                end
            endcase
        end
    end

    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = head_r;
    assign occupancy = cnt_r;

endmodule

// File: rtl/fifo_ast_source.sv
// Drains a FIFO read port into an Avalon-ST source honouring READY_LATENCY,
// framing the stream into fixed-length packets with sop/eop/empty.
module fifo_ast_source
    import fifo_ast_pkg::*;
#(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    parameter int EMPTY_W             = width_min1(SYMBOLS_PER_BEAT),
    parameter int READY_LATENCY       = 2,
    parameter int PKT_LEN             = 4,
    parameter int LAST_EMPTY          = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   fifo_data_i,
    input  logic               fifo_nempty_i,
    output logic               fifo_rd_o,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               sop_o,
    output logic               eop_o,
    output logic [EMPTY_W-1:0] empty_o
);

    localparam int RL = (READY_LATENCY < RL_MIN) ? RL_MIN :
                        (READY_LATENCY > RL_MAX) ? RL_MAX : READY_LATENCY;
    localparam int CNT_W = width_min1(PKT_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PKT_LEN - 1);
    localparam logic [EMPTY_W-1:0] EMPTY_LAST = EMPTY_W'(LAST_EMPTY);

    logic             rd_s;
    logic             inflight_r;
    logic             beat_valid_s;
    logic [WIDTH-1:0] beat_data_s;
    logic             xfer_s;
    logic [CNT_W-1:0] beat_cnt_r;

    // Flags that fifo_data_i carries a word popped in the previous cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_s;
        end
    end

    generate
        if (RL == 0) begin : g_skid
            logic [1:0] occ_s;
            logic [2:0] level_s;

            ast_skid_buffer #(.W(WIDTH)) u_skid (
                .clk       (clk_i),
                .rst_n     (rst_i),
                .in_valid  (inflight_r),
                .in_data   (fifo_data_i),
                .out_ready (ready_i),
                .out_valid (beat_valid_s),
                .out_data  (beat_data_s),
                .occupancy (occ_s)
            );

            // Occupancy is counted after this cycle's transfer so that a
            // continuously ready sink sees one beat per clock.
            assign xfer_s  = beat_valid_s & ready_i;
            assign level_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, xfer_s};
            assign rd_s    = rst_i & fifo_nempty_i & (level_s < 3'd2);
        end else begin : g_latency
            assign rd_s   = rst_i & ready_i & fifo_nempty_i;
            assign xfer_s = beat_valid_s;

            if (RL == 1) begin : g_direct
                assign beat_valid_s = inflight_r;
                assign beat_data_s  = fifo_data_i;
            end else begin : g_pipe
                localparam int ST = RL - 1;
                logic             vld_r [ST];
                logic [WIDTH-1:0] dat_r [ST];

                // First delay stage captures the returning FIFO word.
                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        vld_r[0] <= 1'b0;
                        dat_r[0] <= '0;
                    end else begin
                        vld_r[0] <= inflight_r;
                        dat_r[0] <= fifo_data_i;
                    end
                end

                for (genvar i = 1; i < ST; i++) begin : g_stage
                    // Further delay stages up to the ready latency.
                    always_ff @(posedge clk_i or negedge rst_i) begin
                        if (!rst_i) begin
                            vld_r[i] <= 1'b0;
                            dat_r[i] <= '0;
                        end else begin
                            vld_r[i] <= vld_r[i-1];
                            dat_r[i] <= dat_r[i-1];
                        end
                    end
                end

                assign beat_valid_s = vld_r[ST-1];
                assign beat_data_s  = dat_r[ST-1];
            end
        end
    endgenerate

    // Packet position advances only on beats that actually transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beat_cnt_r <= '0;
        end else if (xfer_s) begin
            beat_cnt_r <= (beat_cnt_r == CNT_LAST) ? '0 : beat_cnt_r + CNT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign fifo_rd_o = rd_s;
    assign valid_o   = beat_valid_s;
    assign data_o    = beat_valid_s ? beat_data_s : '0;
    assign sop_o     = beat_valid_s & (beat_cnt_r == '0);
    assign eop_o     = beat_valid_s & (beat_cnt_r == CNT_LAST);
    assign empty_o   = eop_o ? EMPTY_LAST : '0;

endmodule

// File: tb/tb_fifo_ast_source.sv
// Directed bench: DUT A (RL=2, 4-beat packets) and DUT B (RL=0, 3-beat
// packets, empty=2 on eop), each fed by a small FIFO model.
module tb_fifo_ast_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- DUT A ----------------
    logic        rst_a   = 1'b0;
    logic        ready_a = 1'b0;
    logic        rd_a, valid_a, sop_a, eop_a, ne_a;
    logic [31:0] data_a;
    logic [1:0]  empty_a;
    logic [31:0] fd_a = 32'h0;
    logic [31:0] mem_a [0:63];
    int          wp_a = 0;
    int          rp_a = 0;

    assign ne_a = (wp_a != rp_a);
    always @(posedge clk) begin
        if (rd_a && ne_a) begin
            fd_a <= mem_a[rp_a];
            rp_a <= rp_a + 1;
        end
    end

    fifo_ast_source #(.READY_LATENCY(2), .PKT_LEN(4), .LAST_EMPTY(0)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .fifo_data_i(fd_a), .fifo_nempty_i(ne_a),
        .fifo_rd_o(rd_a), .ready_i(ready_a), .valid_o(valid_a), .data_o(data_a),
        .sop_o(sop_a), .eop_o(eop_a), .empty_o(empty_a)
    );

    // ---------------- DUT B ----------------
    logic        rst_b   = 1'b0;
    logic        ready_b = 1'b0;
    logic        rd_b, valid_b, sop_b, eop_b, ne_b;
    logic [31:0] data_b;
    logic [1:0]  empty_b;
    logic [31:0] fd_b = 32'h0;
    logic [31:0] mem_b [0:63];
    int          wp_b = 0;
    int          rp_b = 0;

    assign ne_b = (wp_b != rp_b);
    always @(posedge clk) begin
        if (rd_b && ne_b) begin
            fd_b <= mem_b[rp_b];
            rp_b <= rp_b + 1;
        end
    end

    fifo_ast_source #(.READY_LATENCY(0), .PKT_LEN(3), .LAST_EMPTY(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .fifo_data_i(fd_b), .fifo_nempty_i(ne_b),
        .fifo_rd_o(rd_b), .ready_i(ready_b), .valid_o(valid_b), .data_o(data_b),
        .sop_o(sop_b), .eop_o(eop_b), .empty_o(empty_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_a(input logic [31:0] v);
        mem_a[wp_a] = v;
        wp_a++;
    endtask

    task automatic push_b(input logic [31:0] v);
        mem_b[wp_b] = v;
        wp_b++;
    endtask

    // Waits (bounded) for the next valid beat of DUT A; returns at negedge+1.
    task automatic wait_beat_a(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (valid_a) got = 1'b1;
        end
        chk(name, got, 1'b1);
    endtask

    typedef struct {
        logic        ready;
        logic        exp_rd;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_sop;
        logic        exp_eop;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic rd, input logic v,
                                 input logic [31:0] d, input logic s, input logic e);
        vec_t t;
        t.ready = r; t.exp_rd = rd; t.exp_valid = v;
        t.exp_data = d; t.exp_sop = s; t.exp_eop = e;
        return t;
    endfunction

    vec_t tbl [22];
    logic exp_sop_b [6];
    logic exp_eop_b [6];
    logic [1:0] exp_emp_b [6];

    initial begin
        // Test 1: 8 words, ready held high, first beat two cycles after first pop.
        tbl[0]  = mkv(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[1]  = mkv(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[2]  = mkv(1'b1, 1'b1, 1'b1, 32'hA0, 1'b1, 1'b0);
        tbl[3]  = mkv(1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0);
        tbl[4]  = mkv(1'b1, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0);
        tbl[5]  = mkv(1'b1, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b1);
        tbl[6]  = mkv(1'b1, 1'b1, 1'b1, 32'hA4, 1'b1, 1'b0);
        tbl[7]  = mkv(1'b1, 1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
        tbl[8]  = mkv(1'b1, 1'b0, 1'b1, 32'hA6, 1'b0, 1'b0);
        tbl[9]  = mkv(1'b1, 1'b0, 1'b1, 32'hA7, 1'b0, 1'b1);
        tbl[10] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[11] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        // Test 2: ready toggling; valid follows ready two clocks later.
        tbl[12] = mkv(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[13] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[14] = mkv(1'b1, 1'b1, 1'b1, 32'hB0, 1'b1, 1'b0);
        tbl[15] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[16] = mkv(1'b1, 1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
        tbl[17] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[18] = mkv(1'b1, 1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
        tbl[19] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
        tbl[20] = mkv(1'b0, 1'b0, 1'b1, 32'hB3, 1'b0, 1'b1);
        tbl[21] = mkv(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);

        exp_sop_b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_eop_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_emp_b = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};

        // Reset state: both FIFOs non-empty and sinks ready, yet nothing pops.
        for (int i = 0; i < 8; i++) push_a(32'hA0 + 32'(i));
        for (int i = 0; i < 6; i++) push_b(32'hE0 + 32'(i));
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_a", rd_a, 1'b0);
        chk("rst_valid_a", valid_a, 1'b0);
        chk("rst_data_a", data_a, 32'h0);
        chk("rst_sop_eop_a", {sop_a, eop_a}, 2'b00);
        chk("rst_empty_a", empty_a, 2'd0);
        chk("rst_rd_b", rd_b, 1'b0);
        chk("rst_valid_b", valid_b, 1'b0);
        ready_a = 1'b0;
        ready_b = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;

        // Tests 1 and 2, table driven on DUT A.
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 12) begin
                for (int i = 0; i < 4; i++) push_a(32'hB0 + 32'(i));
            end
            ready_a = tbl[k].ready;
            #1;
            chk($sformatf("t12_rd[%0d]", k), rd_a, tbl[k].exp_rd);
            chk($sformatf("t12_valid[%0d]", k), valid_a, tbl[k].exp_valid);
            chk($sformatf("t12_empty[%0d]", k), empty_a, 2'd0);
            if (tbl[k].exp_valid) begin
                chk($sformatf("t12_data[%0d]", k), data_a, tbl[k].exp_data);
                chk($sformatf("t12_sop[%0d]", k), sop_a, tbl[k].exp_sop);
                chk($sformatf("t12_eop[%0d]", k), eop_a, tbl[k].exp_eop);
            end
        end

        // Test 5: FIFO runs dry after two beats; framing resumes at beat 2.
        ready_a = 1'b1;
        push_a(32'hC0);
        push_a(32'hC1);
        wait_beat_a("t5_beat0");
        chk("t5_data0", data_a, 32'hC0);
        chk("t5_sop0", sop_a, 1'b1);
        wait_beat_a("t5_beat1");
        chk("t5_data1", data_a, 32'hC1);
        chk("t5_sopeop1", {sop_a, eop_a}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5_gap[%0d]", i), valid_a, 1'b0);
        end
        push_a(32'hC2);
        push_a(32'hC3);
        wait_beat_a("t5_beat2");
        chk("t5_data2", data_a, 32'hC2);
        chk("t5_sopeop2", {sop_a, eop_a}, 2'b00);
        wait_beat_a("t5_beat3");
        chk("t5_data3", data_a, 32'hC3);
        chk("t5_sopeop3", {sop_a, eop_a}, 2'b01);

        // Test 6: reset after beat 2; in-flight word dropped, new packet follows.
        for (int i = 0; i < 8; i++) push_a(32'hD0 + 32'(i));
        wait_beat_a("t6_beat0");
        chk("t6_sop0", sop_a, 1'b1);
        wait_beat_a("t6_beat1");
        chk("t6_data1", data_a, 32'hD1);
        rst_a = 1'b0;
        #1;
        chk("t6_rst_valid", valid_a, 1'b0);
        chk("t6_rst_rd", rd_a, 1'b0);
        chk("t6_rst_data", data_a, 32'h0);
        chk("t6_rst_sopeop", {sop_a, eop_a}, 2'b00);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        wait_beat_a("t6_beat_after");
        chk("t6_data_after", data_a, 32'hD3);
        chk("t6_sop_after", sop_a, 1'b1);

        // Test 3: zero latency, sink stalled; two words buffered, rest stay queued.
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1;
            if (i >= 2) begin
                chk($sformatf("t3_valid[%0d]", i), valid_b, 1'b1);
                chk($sformatf("t3_data[%0d]", i), data_b, 32'hE0);
                chk($sformatf("t3_sop[%0d]", i), sop_b, 1'b1);
            end
        end
        chk("t3_pops", 32'(rp_b), 32'd2);
        chk("t3_rd_stalled", rd_b, 1'b0);
        chk("t3_fifo_left", ne_b, 1'b1);

        // Test 4: drain six beats in 3-beat packets, empty=2 on each eop.
        begin
            int nb;
            nb = 0;
            for (int i = 0; i < 40 && nb < 6; i++) begin
                @(negedge clk);
                ready_b = 1'b1;
                #1;
                if (valid_b) begin
                    chk($sformatf("t4_data[%0d]", nb), data_b, 32'hE0 + 32'(nb));
                    chk($sformatf("t4_sop[%0d]", nb), sop_b, exp_sop_b[nb]);
                    chk($sformatf("t4_eop[%0d]", nb), eop_b, exp_eop_b[nb]);
                    chk($sformatf("t4_empty[%0d]", nb), empty_b, exp_emp_b[nb]);
                    nb++;
                end
            end
            chk("t4_beat_count", 32'(nb), 32'd6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
